// File: rtl/uart_tx_mmio_if.sv
// CPU memory-bus bundle for the UART transmitter window.
// master = CPU side, slave = peripheral side.
interface uart_tx_mmio_if;
  logic [15:0] address;
  logic [15:0] data_out;
  logic        wren_n;
  logic        oen_n;
  logic [15:0] data_in;
  logic        sel;

  modport master (
    output address, data_out, wren_n, oen_n,
    input  data_in, sel
  );

  modport slave (
    input  address, data_out, wren_n, oen_n,
    output data_in, sel
  );
endinterface

// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter: 4-word register window, TX FIFO,
// programmable bit divisor, registered glitch-free tx line.
module uart_tx_mmio #(
  parameter logic [15:0] BASE_ADDR    = 16'hFF00,
  parameter logic [15:0] CLKS_PER_BIT = 16'd104,
  parameter int          FIFO_DEPTH   = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  uart_tx_mmio_if.slave  bus,
  output logic           tx
);

  localparam int            PW       = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [3:0]    DEPTH_C  = 4'(FIFO_DEPTH);
  localparam logic [PW-1:0] LAST_PTR = PW'(FIFO_DEPTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_e;

  state_e          state_q, state_d;
  logic [7:0]      fifo_q [FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [3:0]      count_q, count_d;
  logic            overrun_q, overrun_d;
  logic [15:0]     div_q, div_d;
  logic            wren_prev_q;
  logic [7:0]      shift_q, shift_d;
  logic [15:0]     bit_div_q, bit_div_d;
  logic [15:0]     bit_cnt_q, bit_cnt_d;
  logic [2:0]      bit_idx_q, bit_idx_d;
  logic            tx_q, tx_d;

  logic            sel, we, we_data, we_stat, we_div;
  logic            full, tx_empty, pop, push_ok, bit_done;
  logic [15:0]     rdata;

  // Address decode and edge-qualified write strobe: one action per wren_n fall.
  assign sel      = (bus.address[15:2] == BASE_ADDR[15:2]);
  assign we       = sel & ~bus.wren_n & wren_prev_q;
  assign we_data  = we & (bus.address[1:0] == 2'd0);
  assign we_stat  = we & (bus.address[1:0] == 2'd1);
  assign we_div   = we & (bus.address[1:0] == 2'd2);

  assign full     = (count_q == DEPTH_C);
  assign tx_empty = (count_q == 4'd0) && (state_q == S_IDLE);
  // Pop is decided before push so a push into a full FIFO with a concurrent pop lands.
  assign pop      = (state_q == S_IDLE) && (count_q != 4'd0);
  assign push_ok  = we_data & (~full | pop);
  assign bit_done = (bit_cnt_q == 16'd0);

  assign bus.sel     = sel;
  assign bus.data_in = rdata;
  assign tx          = tx_q;

  // Zero-latency read mux; reads have no side effects.
  always_comb begin
    rdata = 16'h0000;
    if (sel && !bus.oen_n) begin
      case (bus.address[1:0])
        2'd1:    rdata = {8'h00, count_q, 1'b0, overrun_q, tx_empty, full};
        2'd2:    rdata = div_q;
        default: rdata = 16'h0000;
      endcase
    end
  end

  // Register-file and FIFO bookkeeping next state.
  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    overrun_d = overrun_q;
    div_d     = div_q;
    count_d   = count_q + {3'b000, push_ok} - {3'b000, pop};
    if (push_ok) wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + PW'(1);
    if (pop)     rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + PW'(1);
    if (we_data && full && !pop)         overrun_d = 1'b1;
    else if (we_stat && bus.data_out[2]) overrun_d = 1'b0;
    // A zero divisor would stall the bit timer, so it is stored as 1.
    if (we_div) div_d = (bus.data_out == 16'h0000) ? 16'h0001 : bus.data_out;
  end

  // Transmit FSM next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (pop) state_d = S_START;
      S_START: if (bit_done) state_d = S_DATA;
      S_DATA:  if (bit_done && bit_idx_q == 3'd7) state_d = S_STOP;
      S_STOP:  if (bit_done) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Transmit datapath: bit timer, shifter and the next value of the tx line.
  always_comb begin
    shift_d   = shift_q;
    bit_div_d = bit_div_q;
    bit_cnt_d = bit_cnt_q;
    bit_idx_d = bit_idx_q;
    tx_d      = tx_q;
    case (state_q)
      S_IDLE: begin
        tx_d = 1'b1;
        if (pop) begin
          // Divisor is latched per frame so mid-frame DIV writes wait a frame.
          shift_d   = fifo_q[rd_ptr_q];
          bit_div_d = div_q;
          bit_cnt_d = div_q - 16'd1;
          tx_d      = 1'b0;
        end
      end
      S_START: begin
        if (bit_done) begin
          bit_cnt_d = bit_div_q - 16'd1;
          bit_idx_d = 3'd0;
          tx_d      = shift_q[0];
        end else begin
          bit_cnt_d = bit_cnt_q - 16'd1;
        end
      end
      S_DATA: begin
        if (bit_done) begin
          bit_cnt_d = bit_div_q - 16'd1;
          if (bit_idx_q == 3'd7) begin
            tx_d = 1'b1;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
            shift_d   = {1'b0, shift_q[7:1]};
            tx_d      = shift_q[1];
          end
        end else begin
          bit_cnt_d = bit_cnt_q - 16'd1;
        end
      end
      S_STOP: begin
        tx_d = 1'b1;
        if (!bit_done) bit_cnt_d = bit_cnt_q - 16'd1;
      end
      default: tx_d = 1'b1;
    endcase
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= 4'd0;
      overrun_q   <= 1'b0;
      div_q       <= CLKS_PER_BIT;
      wren_prev_q <= 1'b1;
      shift_q     <= 8'h00;
      bit_div_q   <= 16'd1;
      bit_cnt_q   <= 16'd0;
      bit_idx_q   <= 3'd0;
      tx_q        <= 1'b1;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overrun_q   <= overrun_d;
      div_q       <= div_d;
      wren_prev_q <= bus.wren_n;
      shift_q     <= shift_d;
      bit_div_q   <= bit_div_d;
      bit_cnt_q   <= bit_cnt_d;
      bit_idx_q   <= bit_idx_d;
      tx_q        <= tx_d;
    end
  end

  // FIFO storage; contents need no reset since count gates every read.
  always_ff @(posedge clk) begin
    if (push_ok) fifo_q[wr_ptr_q] <= bus.data_out[7:0];
  end

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Self-checking bench: stores queue expected bytes, a frame monitor pops and
// checks every tx cycle; per-scenario tasks check register reads inline.
module tb_uart_tx_mmio;
  logic clk = 1'b0;
  logic rst_n;
  logic tx;

  uart_tx_mmio_if bus ();

  uart_tx_mmio #(
    .BASE_ADDR(16'hFF00), .CLKS_PER_BIT(16'd104), .FIFO_DEPTH(8)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus.slave), .tx(tx)
  );

  always #5 clk = ~clk;

  int         vectors = 0;
  int         miscompares = 0;
  bit [7:0]   exp_q[$];
  int         mon_div = 104;
  int         frames_done = 0;
  longint     cyc = 0;
  longint     start_cyc = 0;
  longint     end_cyc = 0;

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic bus_write(input logic [15:0] a, input logic [15:0] d);
    bus.address = a; bus.data_out = d; bus.wren_n = 1'b0;
    @(posedge clk); #1 bus.wren_n = 1'b1;
  endtask

  task automatic bus_read(input logic [15:0] a, output logic [15:0] d, output logic s);
    bus.address = a; bus.oen_n = 1'b0;
    @(negedge clk); d = bus.data_in; s = bus.sel;
    @(posedge clk); #1 bus.oen_n = 1'b1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; exp_q.delete();
    idle(3);
    rst_n = 1'b1; mon_div = 104;
  endtask

  task automatic wait_frames(input int target, input int budget, input string nm);
    int k = 0;
    while (frames_done < target && k < budget) begin @(posedge clk); k++; end
    #1;
    vectors++;
    if (frames_done < target) begin
      miscompares++;
      $display("FAIL %s: frames seen %0d, required %0d", nm, frames_done, target);
    end
  endtask

  // Frame monitor: on each START it pops the expected byte and checks tx
  // every cycle of the 10*div-cycle frame.
  task automatic monitor();
    bit       in_f = 1'b0;
    int       fc = 0, fd = 1, bn;
    bit [7:0] b = 8'h00;
    logic     e;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) in_f = 1'b0;
      else begin
        if (!in_f && tx === 1'b0) begin
          if (exp_q.size() == 0) begin
            vectors++; miscompares++;
            $display("FAIL mon_unexpected_start: tx=%b at cycle %0d with no byte queued", tx, cyc);
          end else begin
            b = exp_q.pop_front(); in_f = 1'b1; fc = 0; fd = mon_div; start_cyc = cyc;
          end
        end
        if (in_f) begin
          bn = fc / fd;
          e  = (bn == 0) ? 1'b0 : (bn == 9) ? 1'b1 : b[bn-1];
          vectors++;
          if (tx !== e) begin
            miscompares++;
            $display("FAIL mon_bit: byte %h bit slot %0d cycle %0d tx=%b required %b", b, bn, fc, tx, e);
          end
          fc++;
          if (fc == 10 * fd) begin in_f = 1'b0; frames_done++; end_cyc = cyc; end
        end
      end
    end
  endtask

  task automatic test_reset();
    logic [15:0] d; logic s;
    bus.address = 16'hFF01;
    @(negedge clk);
    vectors++;
    if (bus.data_in !== 16'h0000) begin miscompares++; $display("FAIL reset_idle_data_in: got %h required 0000", bus.data_in); end
    @(posedge clk); #1;
    bus_read(16'hFF01, d, s);
    vectors++; if (d !== 16'h0002) begin miscompares++; $display("FAIL reset_status: got %h required 0002", d); end
    vectors++; if (s !== 1'b1) begin miscompares++; $display("FAIL reset_sel: got %b required 1", s); end
    vectors++; if (tx !== 1'b1) begin miscompares++; $display("FAIL reset_tx: got %b required 1", tx); end
    bus_read(16'hFF02, d, s);
    vectors++; if (d !== 16'd104) begin miscompares++; $display("FAIL reset_div: got %h required 0068", d); end
  endtask

  task automatic test_single_frame();
    logic [15:0] d; logic s; int f0;
    bus_write(16'hFF02, 16'd4); mon_div = 4; idle(1);
    f0 = frames_done;
    exp_q.push_back(8'h55);
    bus_write(16'hFF00, 16'h1255);
    vectors++; if (tx !== 1'b1) begin miscompares++; $display("FAIL single_tx_n1: got %b required 1", tx); end
    bus_read(16'hFF01, d, s);
    vectors++; if (d !== 16'h0010) begin miscompares++; $display("FAIL single_status_n1: got %h required 0010", d); end
    vectors++; if (tx !== 1'b0) begin miscompares++; $display("FAIL single_tx_start_n2: got %b required 0", tx); end
    wait_frames(f0 + 1, 100, "single_frame_done");
    bus_read(16'hFF01, d, s);
    vectors++; if (d !== 16'h0002) begin miscompares++; $display("FAIL single_status_end: got %h required 0002", d); end
  endtask

  task automatic test_back_to_back();
    int f0; longint e1;
    bus_write(16'hFF02, 16'd2); mon_div = 2; idle(1);
    f0 = frames_done;
    exp_q.push_back(8'h3C); exp_q.push_back(8'hC3);
    bus_write(16'hFF00, 16'h003C); idle(1);
    bus_write(16'hFF00, 16'h00C3);
    wait_frames(f0 + 1, 100, "b2b_first");
    e1 = end_cyc;
    wait_frames(f0 + 2, 100, "b2b_second");
    vectors++;
    if (start_cyc - e1 != 2) begin miscompares++; $display("FAIL b2b_gap: got %0d required 2", start_cyc - e1); end
  endtask

  task automatic test_overflow();
    logic [15:0] d; logic s;
    bus_write(16'hFF02, 16'd1000); mon_div = 1000; idle(1);
    for (int i = 0; i < 10; i++) begin
      if (i < 9) exp_q.push_back(8'(8'h10 + i));
      bus_write(16'hFF00, 16'(16'h0010 + i)); idle(1);
    end
    bus_read(16'hFF01, d, s);
    vectors++; if (d !== 16'h0085) begin miscompares++; $display("FAIL ovf_status: got %h required 0085", d); end
    bus_write(16'hFF01, 16'h0004);
    bus_read(16'hFF01, d, s);
    vectors++; if (d !== 16'h0081) begin miscompares++; $display("FAIL ovf_clear: got %h required 0081", d); end
    bus_read(16'hFF02, d, s);
    vectors++; if (d !== 16'd1000) begin miscompares++; $display("FAIL ovf_div: got %h required 03e8", d); end
    do_reset();
  endtask

  task automatic test_strobe_hold();
    logic [15:0] d; logic s;
    bus_write(16'hFF02, 16'd1000); mon_div = 1000; idle(1);
    exp_q.push_back(8'h5A);
    bus.address = 16'hFF00; bus.data_out = 16'h005A; bus.wren_n = 1'b0;
    idle(5);
    bus.wren_n = 1'b1;
    bus_read(16'hFF01, d, s);
    vectors++; if (d !== 16'h0000) begin miscompares++; $display("FAIL hold_one_push: got %h required 0000", d); end
    bus.address = 16'hFF00; bus.oen_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      vectors++;
      if (bus.data_in !== 16'h0000) begin miscompares++; $display("FAIL hold_read_data: got %h required 0000", bus.data_in); end
    end
    @(posedge clk); #1 bus.oen_n = 1'b1;
    bus_read(16'hFF01, d, s);
    vectors++; if (d !== 16'h0000) begin miscompares++; $display("FAIL hold_read_nochange: got %h required 0000", d); end
    do_reset();
  endtask

  task automatic test_divisor();
    logic [15:0] d; logic s; int f0;
    bus_write(16'hFF02, 16'h0000);
    bus_read(16'hFF02, d, s);
    vectors++; if (d !== 16'h0001) begin miscompares++; $display("FAIL div_zero: got %h required 0001", d); end
    mon_div = 1;
    f0 = frames_done;
    exp_q.push_back(8'hA3);
    bus_write(16'hFF00, 16'h00A3);
    wait_frames(f0 + 1, 50, "div1_frame");
    bus_read(16'hFF01, d, s);
    vectors++; if (d !== 16'h0002) begin miscompares++; $display("FAIL div1_status: got %h required 0002", d); end
    bus_read(16'hFEFF, d, s);
    vectors++; if (d !== 16'h0000) begin miscompares++; $display("FAIL miss_data_in: got %h required 0000", d); end
    vectors++; if (s !== 1'b0) begin miscompares++; $display("FAIL miss_sel: got %b required 0", s); end
    bus_write(16'hFEFC, 16'h0077); idle(1);
    bus_write(16'hFEFE, 16'h0009); idle(1);
    bus_write(16'hFEFF, 16'h0004); idle(3);
    bus_read(16'hFF01, d, s);
    vectors++; if (d !== 16'h0002) begin miscompares++; $display("FAIL miss_status: got %h required 0002", d); end
    bus_read(16'hFF02, d, s);
    vectors++; if (d !== 16'h0001) begin miscompares++; $display("FAIL miss_div: got %h required 0001", d); end
  endtask

  task automatic test_reset_mid_frame();
    logic [15:0] d; logic s;
    bus_write(16'hFF02, 16'd4); mon_div = 4; idle(1);
    exp_q.push_back(8'h00);
    bus_write(16'hFF00, 16'h0000);
    idle(18);
    vectors++; if (tx !== 1'b0) begin miscompares++; $display("FAIL mid_bit3_low: got %b required 0", tx); end
    rst_n = 1'b0; exp_q.delete();
    @(posedge clk); #1;
    vectors++; if (tx !== 1'b1) begin miscompares++; $display("FAIL mid_tx_after_reset: got %b required 1", tx); end
    rst_n = 1'b1; mon_div = 104;
    bus_read(16'hFF01, d, s);
    vectors++; if (d !== 16'h0002) begin miscompares++; $display("FAIL mid_status: got %h required 0002", d); end
    bus_read(16'hFF02, d, s);
    vectors++; if (d !== 16'd104) begin miscompares++; $display("FAIL mid_div: got %h required 0068", d); end
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      vectors++;
      if (tx !== 1'b1) begin miscompares++; $display("FAIL mid_no_frame: cycle %0d tx=%b required 1", i, tx); end
    end
    @(posedge clk); #1;
  endtask

  initial begin
    rst_n = 1'b0;
    bus.address = 16'h0000; bus.data_out = 16'h0000;
    bus.wren_n = 1'b1; bus.oen_n = 1'b1;
    fork monitor(); join_none
    idle(3);
    rst_n = 1'b1;
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_overflow();
    test_strobe_hold();
    test_divisor();
    test_reset_mid_frame();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/uart_tx_mmio.md
# uart_tx_mmio

Memory-mapped UART transmitter on the CPU's 16-bit memory bus, downstream of the `cpu` core. It decodes a 4-word window and accepts CPU stores into an 8-entry transmit FIFO. It serialises bytes as 8N1 frames on `tx` and returns status and divisor values on CPU loads. Read data is zero-latency because the core samples `data_in` at the end of the same cycle in which it drives `oen_n` low.

## Interface
- `BASE_ADDR`, default 16'hFF00: window base; must be 4-word aligned.
- `CLKS_PER_BIT`, default 16'd104: reset value of the DIV register.
- `FIFO_DEPTH`, default 8: TX FIFO entries; power of two, at most 15.

- `clk` input 1: single clock; all state updates on the rising edge.
- `rst_n` input 1: synchronous, active-low reset.
- `address` input 16: CPU bus address.
- `data_out` input 16: CPU write data.
- `wren_n` input 1: CPU write strobe, active low.
- `oen_n` input 1: CPU read strobe, active low. The core never asserts both strobes at once.
- `data_in` output 16: read data to the CPU.
- `sel` output 1: combinational window hit, `address[15:2] == BASE_ADDR[15:2]`.
- `tx` output 1: serial line; idles high.

## Operation
- Register map, selected by `address[1:0]`:
  - **0 DATA.** A write pushes `data_out[7:0]`. A read returns 0.
  - **1 STATUS.** A read returns `{8'h0, count[3:0], 1'b0, overrun, tx_empty, full}`. A write with `data_out[2]=1` clears `overrun`; all other bits are ignored.
  - **2 DIV.** A write stores `data_out`, with 0 stored as 1. A read returns DIV.
  - **3 reserved.** Reads return 0; writes are ignored.
- **Write access:** exactly one per falling edge of `wren_n`.
  - A registered `wren_prev` (reset 1) qualifies writes: `we = sel & ~wren_n & wren_prev`.
  - Holding `wren_n` low for several cycles performs one action.
- **Read:** `data_in` is combinational from `address` and the registers when `sel & ~oen_n`. It is 0 otherwise. Reads have no side effects.
- **FIFO:**
  - `full = (count == FIFO_DEPTH)`.
  - A push while full drops the byte and sets sticky `overrun`.
  - On a simultaneous push and pop, the pop is evaluated first, so a push while full with a concurrent pop is accepted and `count` is unchanged.
  - Pointers wrap modulo `FIFO_DEPTH`.
- **Transmit FSM:** IDLE → START → DATA → STOP → IDLE.
  - **IDLE:** if `count != 0`, pop the head into the shift register, latch DIV into `bit_div`, load the bit counter with `bit_div-1`, and go to START.
  - **START:** `tx=0` for `bit_div` cycles, then go to DATA with bit index 0.
  - **DATA:** `tx = shift[0]` for `bit_div` cycles per bit, LSB first. Shift right after each bit. After bit 7, go to STOP.
  - **STOP:** `tx=1` for `bit_div` cycles, then go to IDLE.
  - IDLE may pop again in the cycle it is entered, so back-to-back frames have no idle gap beyond the 1 IDLE cycle.
- `tx_empty = (count == 0) & (state == IDLE)`.
- A DIV write mid-frame takes effect at the next frame only.
- An address miss has no effect; `sel=0` and `data_in=0`.

## Timing
- **Reset (`rst_n=0` at an edge):**
  - `state` = IDLE, `tx` = 1 (registered), `count` = 0, pointers = 0, `overrun` = 0, DIV = `CLKS_PER_BIT`, `wren_prev` = 1.
  - Combinational outputs follow the inputs: `data_in=0` unless a read hits; `sel` reflects `address`.
- Reset asserted mid-frame aborts the frame. `tx=1` from the next cycle and the FIFO contents are discarded.
- **DATA write latency:**
  - Write cycle N gives `count=1` at N+1.
  - IDLE pops at N+1, and START (`tx=0`) is visible from N+2.
- Frame length is `10*bit_div` cycles, from the first START cycle to the last STOP cycle.
- STATUS reflects state as of the last edge. A STATUS read in the same cycle as a push shows the pre-push value.
- `tx` is a registered output and is glitch-free.

## Test plan
- **Post-reset state.** Release reset, then read STATUS → `data_in=16'h0002`. `tx=1` and `sel=1` during the access.
- **Single frame.** Write DIV=4, then write DATA=16'h1255.
  - `tx=0` for cycles N+2..N+5.
  - Data bits 1,0,1,0,1,0,1,0, 4 cycles each.
  - Stop bit high for 4 cycles.
  - STATUS reads 16'h0002 after cycle N+41.
- **Overflow.** Write DIV=1000, then 10 DATA writes separated by 1-cycle strobe gaps.
  - First byte goes to the shifter; 8 are queued; the 10th is dropped.
  - STATUS reads 16'h0085 (`count=8`, `overrun=1`, `full=1`).
  - Writing STATUS=16'h0004 then gives 16'h0081.
- **Strobe hold.** Hold `wren_n` low for 5 cycles on DATA with DIV=1000 → exactly one push (`count` 1, then 0 after the pop). Holding `oen_n` low on DATA returns 0 with no state change.
- **Divisor edge cases.**
  - Write DIV=0, then read DIV → 16'h0001; a frame lasts 10 cycles.
  - Read and write at address 16'hFEFF → `sel=0`, `data_in=0`, no state change.
- **Reset mid-frame.** Assert `rst_n=0` during DATA bit 3 → `tx=1` next cycle, STATUS 16'h0002, DIV back to 104, no further frame output.
